tmds_gearbox: RTL
=================

TMDS_GEARBOX -- requirements
Module: tmds_gearbox

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 3: number of parallel data lanes.
REQ-002 SHALL have parameter WORD_WIDTH, default 10: symbol width per lane.
REQ-003 SHALL have parameter LANE_BITS, default 2: bits emitted per lane per clock; WORD_WIDTH % LANE_BITS == 0, else elaboration error.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: input word FIFO depth; power of two, >= 2.
REQ-005 SHALL have parameter MSB_FIRST, default 0: 0 = symbol bit 0 leaves first; 1 = bit WORD_WIDTH-1 leaves first.
REQ-006 SHALL have parameter IDLE_WORD, default 10'b1101010100: symbol sent on every lane when no data is available.
REQ-007 SHALL have port clk_pixel_x5, input, 1: sole clock, all logic on rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-009 SHALL have port in_valid, input, 1: in_data holds a word set.
REQ-010 SHALL have port in_ready, output, 1: FIFO can accept a word set.
REQ-011 SHALL have port in_data, input, NUM_CHANNELS*WORD_WIDTH: lane i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-012 SHALL have port out_bits, output, NUM_CHANNELS*LANE_BITS: lane i at [i*LANE_BITS +: LANE_BITS], bit 0 earlier in time (for external DDR/ODDR primitive).
REQ-013 SHALL have port out_valid, output, 1: high while out_bits carry FIFO data, low while carrying IDLE_WORD.
REQ-014 SHALL have port underflow, output, 1: one-cycle pulse on a data-starved word boundary in STREAM.
REQ-015 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-016 SHALL define SLOTS = WORD_WIDTH/LANE_BITS; free-running slot counter 0..SLOTS-1, wraps SLOTS-1 -> 0; the cycle with slot == SLOTS-1 is the load cycle.
REQ-017 SHALL push in_data into the FIFO on every cycle with in_valid && in_ready; in_ready = !full, no write bypass when full, even on a simultaneous pop.
REQ-018 SHALL, on a load-cycle edge, load all lane shift registers at once with FIFO head (pop) or IDLE_WORD per REQ-020/021; all other edges shift each lane by LANE_BITS in direction set by MSB_FIRST.
REQ-019 SHALL register out_bits directly from shift registers: first LANE_BITS of a loaded word appear the cycle after the load edge; a word fully drains in SLOTS cycles.
REQ-020 SHALL implement FSM IDLE/STREAM: IDLE loads IDLE_WORD, no pop; IDLE -> STREAM at a load edge with fifo_level >= FIFO_DEPTH/2, that load pops.
REQ-021 SHALL, in STREAM at a load edge: if FIFO non-empty pop and load; if empty load IDLE_WORD, pulse underflow next cycle, go to IDLE.
REQ-022 SHALL hold out_valid high exactly for the SLOTS cycles carrying a popped word.
REQ-023 SHALL treat a push in the same cycle as a load edge as invisible to that load decision (level sampled before push).
REQ-024 SHALL update fifo_level +1 on push only, -1 on pop only, unchanged on both; never exceed FIFO_DEPTH nor go below 0.

Reset
REQ-025 SHALL, while reset == 0 at a clock edge: slot=0, FSM=IDLE, FIFO empty, fifo_level=0, out_bits=0, out_valid=0, underflow=0, in_ready=0.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset release; reset mid-word discards shift contents and FIFO without completing the word.

Configuration
REQ-027 SHALL, with TMDS_GEARBOX_CLOCK_LANE_EN defined, add output clk_lane_bits (LANE_BITS), loaded at every load edge with WORD_WIDTH/2 ones in LSBs (10'b0000011111 default), shifted and ordered like data lanes, reset 0, independent of FSM state.
REQ-028 SHALL, without TMDS_GEARBOX_CLOCK_LANE_EN, omit clk_lane_bits and all its logic; other behaviour identical.

Verification (defaults: SLOTS=5)
REQ-029 SHALL cover: reset low 3 cycles then high, no input -> out_bits = IDLE_WORD pairs {00,01,01,01,11} (LSB-first) repeating, out_valid=0, underflow=0.
REQ-030 SHALL cover: push 2 words 10'h3FF then 10'h000 on all lanes -> STREAM at next load edge, out_valid high 10 cycles, out_bits 11 x5 then 00 x5.
REQ-031 SHALL cover: push 4 words, hold in_valid -> in_ready=0, fifo_level=4; 5th word accepted only after first pop.
REQ-032 SHALL cover: stream 3 words then stop -> underflow single pulse 1 cycle after the 4th load edge, out_valid falls, FSM IDLE.
REQ-033 SHALL cover: MSB_FIRST=1, word 10'b1000000001 -> out_bits pairs {11? no: bit9,bit8}={1,0}, then 00,00,00,{0,1}; reset asserted mid-word -> out_bits=0 next cycle.
REQ-034 SHALL cover: TMDS_GEARBOX_CLOCK_LANE_EN defined -> clk_lane_bits = 11,11,01,00,00 per word, aligned with data slots, unaffected by underflow.

Source files
------------

// File: rtl/tmds_gearbox.sv
// tmds_gearbox: word-to-lane serializer gearbox with input FIFO and idle-symbol insertion.
// Optional clock lane output is enabled by defining TMDS_GEARBOX_CLOCK_LANE_EN.
// Ports:
//   clk_pixel_x5  - sole clock, rising edge
//   reset         - synchronous, active-low
//   in_valid/in_ready/in_data - word-set input, lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//   out_bits      - LANE_BITS per lane per clock, bit 0 earlier in time
//   out_valid     - high while out_bits carry FIFO data
//   underflow     - one-cycle pulse when a streaming word boundary finds the FIFO empty
//   fifo_level    - current FIFO occupancy
//   clk_lane_bits - (TMDS_GEARBOX_CLOCK_LANE_EN only) serialized clock pattern
module tmds_gearbox #(
    parameter int NUM_CHANNELS = 3,
    parameter int WORD_WIDTH = 10,
    parameter int LANE_BITS = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST = 0,
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                              clk_pixel_x5,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] in_data,
    output logic [NUM_CHANNELS*LANE_BITS-1:0]  out_bits,
    output logic                              out_valid,
    output logic                              underflow,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
`ifdef TMDS_GEARBOX_CLOCK_LANE_EN
    ,
    output logic [LANE_BITS-1:0]              clk_lane_bits
`endif
);
    localparam int SLOTS = WORD_WIDTH / LANE_BITS;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW = NUM_CHANNELS * WORD_WIDTH;

    if (WORD_WIDTH % LANE_BITS != 0) begin : g_bad_lane_bits
        $error("tmds_gearbox: WORD_WIDTH must be a multiple of LANE_BITS");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tmds_gearbox: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_slot;
    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;
    logic [DW-1:0] r_sr;
    logic          r_vld;
    logic          r_uf;
    logic          r_rdy;
    logic [DW-1:0] w_sr_shift;
    logic [DW-1:0] w_load_word;
    logic          w_load;
    logic          w_full;
    logic          w_empty;
    logic          w_half;
    logic          w_push;
    logic          w_pop;
    logic          w_uf;

    // Load decisions use the registered level, so a same-cycle push is not seen.
    assign w_load      = r_slot == SW'(SLOTS - 1);
    assign w_full      = r_level == (AW+1)'(FIFO_DEPTH);
    assign w_empty     = r_level == '0;
    assign w_half      = r_level >= (AW+1)'(FIFO_DEPTH / 2);
    assign in_ready    = r_rdy && !w_full;
    assign w_push      = in_valid && in_ready;
    assign w_load_word = w_pop ? r_mem[r_rd] : {NUM_CHANNELS{IDLE_WORD}};
    assign out_valid   = r_vld;
    assign underflow   = r_uf;
    assign fifo_level  = r_level;

    always_ff @(posedge clk_pixel_x5) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = !w_load ? r_state :
                      (r_state == S_IDLE) ? (w_half ? S_STREAM : S_IDLE) :
                      (w_empty ? S_IDLE : S_STREAM);
    end

    always_comb begin
        w_pop = w_load && ((r_state == S_IDLE) ? w_half : !w_empty);
        w_uf  = w_load && r_state == S_STREAM && w_empty;
    end

    always_comb begin
        w_sr_shift = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            w_sr_shift[i*WORD_WIDTH +: WORD_WIDTH] = (MSB_FIRST != 0) ?
                r_sr[i*WORD_WIDTH +: WORD_WIDTH] << LANE_BITS :
                r_sr[i*WORD_WIDTH +: WORD_WIDTH] >> LANE_BITS;
    end

    always_ff @(posedge clk_pixel_x5) begin
        if (w_push)
            r_mem[r_wr] <= in_data;
    end

    always_ff @(posedge clk_pixel_x5) begin
        if (!reset) begin
            r_slot  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_sr    <= '0;
            r_vld   <= 1'b0;
            r_uf    <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_slot  <= w_load ? '0 : r_slot + SW'(1);
            r_rdy   <= 1'b1;
            r_uf    <= w_uf;
            r_sr    <= w_load ? w_load_word : w_sr_shift;
            r_vld   <= w_load ? w_pop : r_vld;
            r_wr    <= w_push ? r_wr + AW'(1) : r_wr;
            r_rd    <= w_pop ? r_rd + AW'(1) : r_rd;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // The bits leaving next sit at the bottom of each lane (LSB-first) or the top (MSB-first).
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        for (genvar k = 0; k < LANE_BITS; k++) begin : g_bit
            assign out_bits[i*LANE_BITS+k] =
                r_sr[i*WORD_WIDTH + ((MSB_FIRST != 0) ? WORD_WIDTH-1-k : k)];
        end
    end

`ifdef TMDS_GEARBOX_CLOCK_LANE_EN
    localparam logic [WORD_WIDTH-1:0] CLK_WORD =
        {{(WORD_WIDTH - WORD_WIDTH/2){1'b0}}, {(WORD_WIDTH/2){1'b1}}};

    logic [WORD_WIDTH-1:0] r_clk_sr;

    // Clock pattern reloads every word regardless of FSM state or FIFO contents.
    always_ff @(posedge clk_pixel_x5) begin
        if (!reset)
            r_clk_sr <= '0;
        else
            r_clk_sr <= w_load ? CLK_WORD :
                        (MSB_FIRST != 0) ? r_clk_sr << LANE_BITS : r_clk_sr >> LANE_BITS;
    end

    for (genvar k = 0; k < LANE_BITS; k++) begin : g_clk_bit
        assign clk_lane_bits[k] = r_clk_sr[(MSB_FIRST != 0) ? WORD_WIDTH-1-k : k];
    end
`endif
endmodule
